// File: rtl/dff_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_chain_pkg
// Purpose  : Shared types and width helpers for the dff_1 chain serial loader.
// Revision : 1.0 - initial release
// ============================================================================
package dff_chain_pkg;

  // Loader sequencing: wait, data settle with SCLK low, SCLK high, strobe.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_e;

  // Phase timer must hold DIV-1; sized one above so DIV=1 still gets a bit.
  function automatic int phase_cnt_w(input int div);
    return $clog2(div + 1);
  endfunction

  // Bit counter must hold WIDTH-1; same sizing rule as the phase timer.
  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dff_chain_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module   : dff_chain_phase_cnt
// Purpose  : Loadable down counter that parks at zero; terminal count flags
//            the last cycle of a serial-clock half period.
// Revision : 1.0 - initial release
// ============================================================================
module dff_chain_phase_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on request, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : dff_chain_loader
// Purpose  : Shifts a parallel word MSB-first into a dff_1 shift chain with a
//            divided serial clock, then pulses the shadow-register strobe.
//            SDATA only moves on SCLK falling edges, so every rising edge has
//            DIV cycles of setup and hold.
// Revision : 1.0 - initial release
// ============================================================================
module dff_chain_loader
  import dff_chain_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] DATA,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             SCLK,
  output logic             SDATA,
  output logic             SLOAD
);

  localparam int PCW = phase_cnt_w(DIV);
  localparam int BCW = bit_cnt_w(WIDTH);
  localparam logic [PCW-1:0] PHASE_INIT = PCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_INIT   = BCW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             sload_q, sload_d;
  logic             phase_load;
  logic             phase_tc;

  dff_chain_phase_cnt #(
    .CNT_W (PCW)
  ) u_phase_cnt (
    .clk      (CLK),
    .rst_n    (RN),
    .load     (phase_load),
    .load_val (PHASE_INIT),
    .tc       (phase_tc)
  );

  // Next state, shift/bit-count updates, and next values of the output flops.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    phase_load = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = SETUP;
          shreg_d    = DATA;
          bitcnt_d   = BIT_INIT;
          phase_load = 1'b1;
        end
      end
      SETUP: begin
        if (phase_tc) begin
          state_d    = HIGH;
          phase_load = 1'b1;
        end
      end
      HIGH: begin
        if (phase_tc) begin
          phase_load = 1'b1;
          if (bitcnt_q != '0) begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - BCW'(1);
            state_d  = SETUP;
          end else begin
            state_d  = LATCH;
          end
        end
      end
      LATCH: begin
        if (phase_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the upcoming state so they register cleanly.
    busy_d  = (state_d != IDLE);
    sclk_d  = (state_d == HIGH);
    sload_d = (state_d == LATCH);
    sdata_d = ((state_d == SETUP) || (state_d == HIGH)) && shreg_d[WIDTH-1];
  end

  // State, datapath and output registers; reset drops every output at once.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sload_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      sload_q  <= sload_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign SCLK  = sclk_q;
  assign SDATA = sdata_q;
  assign SLOAD = sload_q;

endmodule
`default_nettype wire

// File: tb/tb_dff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_chain_loader
// Purpose  : Self-checking bench for dff_chain_loader (WIDTH=8/DIV=2 and
//            WIDTH=1/DIV=1) with a timeline model and a dff_1 chain model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_chain_loader;

  localparam int W    = 8;
  localparam int D    = 2;
  localparam int XFER = (2 * W + 1) * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rn    = 1'b1;
  logic [W-1:0] data  = '0;
  logic         start = 1'b0;
  logic         busy, done, sclk, sdata, sload;
  logic [0:0]   data1  = '0;
  logic         start1 = 1'b0;
  logic         busy1, done1, sclk1, sdata1, sload1;

  dff_chain_loader #(.WIDTH(W), .DIV(D)) dut (
    .CLK(clk), .RN(rn), .DATA(data), .START(start),
    .BUSY(busy), .DONE(done), .SCLK(sclk), .SDATA(sdata), .SLOAD(sload)
  );

  dff_chain_loader #(.WIDTH(1), .DIV(1)) dut1 (
    .CLK(clk), .RN(rn), .DATA(data1), .START(start1),
    .BUSY(busy1), .DONE(done1), .SCLK(sclk1), .SDATA(sdata1), .SLOAD(sload1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference transfer: start cycle and captured word.
  bit           have_tx = 1'b0;
  int           t0      = 0;
  logic [W-1:0] word    = '0;

  // Downstream dff_1 chain and its shadow register.
  logic [W-1:0] chain  = '0;
  logic [W-1:0] shadow = '0;
  always @(posedge sclk)  chain  <= {chain[W-2:0], sdata};
  always @(posedge sload) shadow <= chain;

  int         done_cyc   = -1;
  int         done_total = 0;
  int         rises[$];
  int         sloads[$];
  logic [4:0] trace[$];
  logic [4:0] trace_a[$];
  logic       prev_sclk  = 1'b0;
  logic       prev_sdata = 1'b0;
  int         last_rise  = -100;
  int         last_chg   = -100;
  logic [4:0] exp_o, act_o;
  int         ta, tb0, tc, tc2, td, tr, tw, base, n, mism;
  logic [4:0] w1_exp [5] = '{5'b10010, 5'b10110, 5'b10001, 5'b01000, 5'b00000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
    end
  endtask

  // Expected {BUSY,DONE,SCLK,SDATA,SLOAD} 'off' cycles after the start cycle.
  function automatic logic [4:0] model_out(input int off, input logic [W-1:0] w);
    logic [4:0] r;
    r = '0;
    if (off >= 1 && off <= 2 * W * D) begin
      r[4] = 1'b1;
      r[2] = (((off - 1) / D) % 2) == 1;
      r[1] = w[W - 1 - (off - 1) / (2 * D)];
    end else if (off >= 1 && off <= XFER) begin
      r[4] = 1'b1;
      r[0] = 1'b1;
    end else if (off == XFER + 1) begin
      r[3] = 1'b1;
    end
    return r;
  endfunction

  function automatic bit model_busy(input int c);
    return have_tx && (c - t0) >= 1 && (c - t0) <= XFER;
  endfunction

  // Per-cycle compare against the model, event recording and margin checks.
  initial forever begin
    @(posedge clk);
    if (rn && start && !model_busy(cyc)) begin
      have_tx = 1'b1;
      t0      = cyc;
      word    = data;
    end
    cyc = cyc + 1;
    #1;
    if (!rn) have_tx = 1'b0;
    exp_o = have_tx ? model_out(cyc - t0, word) : 5'b0;
    act_o = {busy, done, sclk, sdata, sload};
    chk("outputs", 32'(act_o), 32'(exp_o));
    if (exp_o[3]) chk("chain_word", 32'(shadow), 32'(word));
    trace.push_back(act_o);
    if (done) begin
      done_cyc = cyc;
      done_total++;
    end
    if (sload) sloads.push_back(cyc);
    if (sclk && !prev_sclk) rises.push_back(cyc);
    if (rn) begin
      if (sdata !== prev_sdata) begin
        chk("hold_margin", 32'((cyc - last_rise) >= D), 32'd1);
        last_chg = cyc;
      end
      if (sclk && !prev_sclk) begin
        chk("setup_margin", 32'((cyc - last_chg) >= D), 32'd1);
        last_rise = cyc;
      end
    end else begin
      last_rise = -100;
      last_chg  = -100;
    end
    prev_sclk  = sclk;
    prev_sdata = sdata;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_rec();
    rises.delete();
    sloads.delete();
    trace.delete();
    done_cyc = -1;
  endtask

  task automatic wait_done(input int bound, input string nm);
    int k;
    k = 0;
    while (done_cyc < 0 && k < bound) begin
      tick();
      k++;
    end
    chk(nm, 32'(done_cyc >= 0), 32'd1);
  endtask

  task automatic start_xfer(input logic [W-1:0] w, output int t);
    clear_rec();
    data  = w;
    start = 1'b1;
    t     = cyc;
    tick();
    start = 1'b0;
    data  = W'($urandom);
  endtask

  initial begin
    #1 rn = 1'b0;
    repeat (3) tick();
    chk("reset_outs", 32'({busy, done, sclk, sdata, sload}), 32'd0);
    chk("reset_outs_w1", 32'({busy1, done1, sclk1, sdata1, sload1}), 32'd0);
    rn = 1'b1;
    tick();

    // Basic 0xA5 transfer with literal timing.
    start_xfer(8'hA5, ta);
    wait_done(60, "a_done_timeout");
    chk("a_rise_count", 32'(rises.size()), 32'd8);
    chk("a_first_rise", 32'(rises.size() > 0 ? rises[0] - ta : -1), 32'd3);
    chk("a_last_rise", 32'(rises.size() > 0 ? rises[rises.size()-1] - ta : -1), 32'd31);
    chk("a_shadow", 32'(shadow), 32'hA5);
    chk("a_sload_count", 32'(sloads.size()), 32'd2);
    chk("a_sload_first", 32'(sloads.size() > 0 ? sloads[0] - ta : -1), 32'd33);
    chk("a_sload_last", 32'(sloads.size() > 0 ? sloads[sloads.size()-1] - ta : -1), 32'd34);
    chk("a_done_cycle", 32'(done_cyc - ta), 32'd35);
    trace_a = trace;
    tick();

    // START pulse at T+10 must be ignored.
    start_xfer(8'hA5, tb0);
    while (cyc < tb0 + 10) tick();
    start = 1'b1;
    data  = 8'h00;
    tick();
    start = 1'b0;
    wait_done(60, "b_done_timeout");
    chk("b_done_cycle", 32'(done_cyc - tb0), 32'd35);
    mism = 0;
    for (int i = 0; i < 35; i++) begin
      if (i >= trace.size() || i >= trace_a.size() || trace[i] !== trace_a[i]) mism++;
    end
    chk("b_trace_same", 32'(mism), 32'd0);
    chk("b_shadow", 32'(shadow), 32'hA5);
    tick();

    // START in the DONE cycle.
    start_xfer(8'hC3, tc);
    wait_done(60, "c1_done_timeout");
    chk("c_done_pulse", 32'(done), 32'd1);
    chk("c_shadow_first", 32'(shadow), 32'hC3);
    clear_rec();
    data  = 8'h3C;
    start = 1'b1;
    tc2   = cyc;
    tick();
    start = 1'b0;
    chk("c_second_busy", 32'(busy), 32'd1);
    wait_done(60, "c2_done_timeout");
    chk("c_second_done", 32'(done_cyc - tc2), 32'd35);
    chk("c_shadow", 32'(shadow), 32'h3C);
    tick();

    // Reset mid-transfer, then restart.
    start_xfer(8'h5A, td);
    while (cyc < td + 12) tick();
    rn = 1'b0;
    #1;
    chk("d_reset_outs", 32'({busy, done, sclk, sdata, sload}), 32'd0);
    tick();
    tick();
    rn = 1'b1;
    repeat (40) tick();
    chk("d_no_sload", 32'(sloads.size()), 32'd0);
    chk("d_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    chk("d_shadow_kept", 32'(shadow), 32'h3C);
    start_xfer(8'hFF, tr);
    wait_done(60, "d_restart_timeout");
    chk("d_restart_done", 32'(done_cyc - tr), 32'd35);
    chk("d_shadow_ff", 32'(shadow), 32'hFF);
    tick();

    // WIDTH=1, DIV=1 instance.
    data1  = 1'b1;
    start1 = 1'b1;
    tw     = cyc;
    tick();
    start1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("w1_off%0d", k), 32'({busy1, done1, sclk1, sdata1, sload1}), 32'(w1_exp[k-1]));
      chk($sformatf("w1_cyc%0d", k), 32'(cyc - tw), 32'(k));
      tick();
    end

    // Random words with random START pulses, including during busy.
    base = done_total;
    n    = 0;
    while ((done_total - base) < 1000 && n < 60000) begin
      data  = W'($urandom);
      start = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    start = 1'b0;
    chk("rand_done_count", 32'((done_total - base) >= 1000), 32'd1);
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
